// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter among NUM_REQ byte producers.
// Holds start_txd/tx_data for the whole ownership and pulses done or err back to the owner.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 150000,
    parameter int unsigned CNT_W          = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [NUM_REQ-1:0]     err,
    output logic                   busy,
    output logic                   start_txd,
    output logic [7:0]             tx_data,
    input  logic                   end_of_txd
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam logic [IdxW:0] NumReqW = (IdxW+1)'(NUM_REQ);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StArb, StXfer, StRelease} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     owner_q, owner_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                busy_q, busy_d;
    logic                start_q, start_d;
    logic [7:0]          data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                eot_q;

    logic                found;
    logic [IdxW-1:0]     win;
    logic [IdxW:0]       cand;
    logic [7:0]          win_data;
    logic                eot_rise;
    logic                timeout;

    // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!found && req[cand[IdxW-1:0]]) begin
                found = 1'b1;
                win   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win == IdxW'(i)) begin
                win_data = req_data[8*i +: 8];
            end
        end
    end

    // A level still high from the previous frame is not a completion.
    assign eot_rise = end_of_txd & ~eot_q;
    assign timeout  = (cnt_q == CntLast);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        err_d    = '0;
        start_d  = start_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        case (state_q)
            StArb: begin
                if (found) begin
                    state_d = StXfer;
                    owner_d = win;
                    gnt_d   = NUM_REQ'(1) << win;
                    data_d  = win_data;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            StXfer: begin
                cnt_d = cnt_q + 1'b1;
                if (eot_rise) begin
                    start_d = 1'b0;
                    done_d  = gnt_q;
                    state_d = StRelease;
                end else if (timeout) begin
                    start_d = 1'b0;
                    err_d   = gnt_q;
                    state_d = StRelease;
                end
            end
            StRelease: begin
                gnt_d    = '0;
                state_d  = StArb;
                rr_ptr_d = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
            end
            default: begin
                state_d = StArb;
                gnt_d   = '0;
                start_d = 1'b0;
            end
        endcase
        busy_d = (state_d != StArb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StArb;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
            eot_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            eot_q    <= end_of_txd;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign start_txd = start_q;
    assign tx_data   = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural 8N1 UART with a line receiver, grant/line scoreboards.
module tb_uart_tx_arbiter;

    localparam int BIT_CYC = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  gnt, done, err;
    logic        busy, start_txd;
    logic [7:0]  tx_data;
    logic        end_of_txd = 1'b0;

    uart_tx_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (1000),
        .CNT_W          (18)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .start_txd  (start_txd),
        .tx_data    (tx_data),
        .end_of_txd (end_of_txd)
    );

    always #5 clk = ~clk;

    // UART model: one bit per BIT_CYC clocks; end_of_txd high for one bit period after stop.
    logic       txd = 1'b1;
    logic       mute = 1'b0;
    int         tcnt = 0;
    int         bitn = 0;
    logic [9:0] shreg = '0;

    always @(posedge clk) begin
        if (tcnt == BIT_CYC - 1) begin
            tcnt <= 0;
            if (mute) begin
                end_of_txd <= 1'b0;
                txd        <= 1'b1;
                bitn       <= 0;
            end else if (bitn == 0) begin
                end_of_txd <= 1'b0;
                if (start_txd) begin
                    shreg <= {1'b1, tx_data, 1'b0};
                    txd   <= 1'b0;
                    bitn  <= 1;
                end
            end else if (bitn < 10) begin
                txd  <= shreg[bitn];
                bitn <= bitn + 1;
            end else begin
                end_of_txd <= 1'b1;
                bitn       <= 0;
            end
        end else begin
            tcnt <= tcnt + 1;
        end
    end

    logic [11:0] exp_gnt_q[$];
    logic [7:0]  exp_line_q[$];
    int n_vec = 0;
    int n_err = 0;
    int grant_cnt = 0;
    int done_tot = 0;
    int err_tot = 0;
    int done_cnt[4] = '{0, 0, 0, 0};
    logic [3:0]  gnt_prev = '0;
    logic [11:0] mon_e;
    logic [7:0]  rx_b;
    logic [7:0]  rx_e;
    logic        rx_stop;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_grant(input int idx, input logic [7:0] b, input bit on_line);
        exp_gnt_q.push_back({4'(1 << idx), b});
        if (on_line) exp_line_q.push_back(b);
    endtask

    function automatic int evt_count(input int which);
        if (which == 0) return grant_cnt;
        if (which == 1) return done_tot;
        return err_tot;
    endfunction

    // Waits for the next grant(0)/done(1)/err(2) event; n counts clocks waited.
    task automatic wait_evt(input string tag, input int which, input int limit, output int n,
                            output bit saw_low);
        int base;
        base    = evt_count(which);
        n       = 0;
        saw_low = 1'b0;
        while (evt_count(which) == base && n < limit) begin
            @(negedge clk);
            #1;
            if (!end_of_txd) saw_low = 1'b1;
            n++;
        end
        chk({tag, "_in_time"}, 32'(n < limit), 32'd1);
    endtask

    // Grant, ownership and done/err monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (gnt !== 4'b0 && gnt_prev === 4'b0) begin
                grant_cnt++;
                if (exp_gnt_q.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'h0);
                end else begin
                    mon_e = exp_gnt_q.pop_front();
                    chk("gnt", 32'(gnt), 32'(mon_e[11:8]));
                    chk("tx_data", 32'(tx_data), 32'(mon_e[7:0]));
                    chk("start_at_gnt", 32'(start_txd), 32'd1);
                end
            end
            if ((done | err) !== 4'b0) begin
                chk("owner_only", 32'((done | err) & ~gnt), 32'h0);
                chk("done_and_err", 32'(done & err), 32'h0);
                for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
                if (done !== 4'b0) done_tot++;
                if (err !== 4'b0) err_tot++;
            end
            gnt_prev = gnt;
        end
    end

    // Line receiver: samples mid-bit and checks bytes in order against the line scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (txd === 1'b0) begin
                repeat (BIT_CYC / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge clk);
                    rx_b[i] = txd;
                end
                repeat (BIT_CYC) @(negedge clk);
                rx_stop = txd;
                chk("stop_bit", 32'(rx_stop), 32'd1);
                if (exp_line_q.size() == 0) begin
                    chk("line_unexpected", 32'(exp_line_q.size()), 32'd1);
                end else begin
                    rx_e = exp_line_q.pop_front();
                    chk("line_byte", 32'(rx_b), 32'(rx_e));
                end
            end
        end
    end

    int n;
    bit saw_low;

    initial begin
        // Reset state.
        rst = 1'b1;
        #2;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_start", 32'(start_txd), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        // Single request on requester 0.
        req_data[7:0] = 8'hA5;
        expect_grant(0, 8'hA5, 1'b1);
        req = 4'b0001;
        wait_evt("single_gnt", 0, 20, n, saw_low);
        chk("grant_latency", 32'(n), 32'd1);
        chk("single_busy", 32'(busy), 32'd1);
        wait_evt("single_done", 1, 2000, n, saw_low);
        chk("single_done", 32'(done), 32'h1);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #1;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("single_done_once", 32'(done_cnt[0]), 32'd1);

        // Async reset mid-transfer of requester 1; rr_ptr would otherwise favour requester 2.
        mute = 1'b1;
        req_data[15:8] = 8'h5A;
        expect_grant(1, 8'h5A, 1'b0);
        req = 4'b0010;
        wait_evt("rst_test_gnt", 0, 20, n, saw_low);
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("async_gnt", 32'(gnt), 32'h0);
        chk("async_start", 32'(start_txd), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk);
        #1;
        req_data[7:0]   = 8'h3C;
        req_data[23:16] = 8'h77;
        expect_grant(0, 8'h3C, 1'b1);
        req  = 4'b0101;
        mute = 1'b0;
        rst  = 1'b0;
        wait_evt("post_rst_gnt", 0, 20, n, saw_low);
        chk("post_rst_req0_first", 32'(gnt), 32'h1);

        // Fairness: requester 0 held, requester 2 pending must be served before 0 again.
        expect_grant(2, 8'h77, 1'b1);
        expect_grant(0, 8'h3C, 1'b1);
        req = 4'b0001;
        repeat (4) @(negedge clk);
        #1;
        req = 4'b0101;
        wait_evt("fair_done0", 1, 2000, n, saw_low);
        wait_evt("fair_gnt2", 0, 20, n, saw_low);
        chk("fair_gnt2", 32'(gnt), 32'h4);
        req = 4'b0001;
        wait_evt("fair_done2", 1, 2000, n, saw_low);
        chk("fair_done2", 32'(done), 32'h4);
        wait_evt("fair_gnt0", 0, 20, n, saw_low);
        chk("fair_gnt0", 32'(gnt), 32'h1);
        req = 4'b0000;
        wait_evt("fair_done0b", 1, 2000, n, saw_low);

        // Timeout: UART silent, requester 1 errors after 1000 clocks, requester 3 follows.
        mute = 1'b1;
        req_data[15:8]  = 8'hC1;
        req_data[31:24] = 8'hD4;
        expect_grant(1, 8'hC1, 1'b0);
        expect_grant(3, 8'hD4, 1'b1);
        req = 4'b1010;
        wait_evt("to_gnt", 0, 20, n, saw_low);
        req = 4'b1000;
        wait_evt("to_err", 2, 3000, n, saw_low);
        chk("to_latency", 32'(n), 32'd1000);
        chk("to_err", 32'(err), 32'h2);
        chk("to_start_low", 32'(start_txd), 32'd0);
        chk("to_no_done", 32'(done_cnt[1]), 32'd0);
        mute = 1'b0;
        wait_evt("to_next_gnt", 0, 20, n, saw_low);
        chk("to_next_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        wait_evt("to_next_done", 1, 2000, n, saw_low);
        chk("to_next_done", 32'(done), 32'h8);

        // Round-robin with all requests held; later grants land on a stale end_of_txd.
        req_data = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            expect_grant(k % 4, 8'(8'h11 * ((k % 4) + 1)), 1'b1);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_evt("rr_gnt", 0, 40, n, saw_low);
            chk("rr_order", 32'(gnt), 32'(1 << (k % 4)));
            if (k > 0) chk("rr_stale_eot", 32'(end_of_txd), 32'd1);
            if (k == 4) req = 4'b0000;
            wait_evt("rr_done", 1, 2000, n, saw_low);
            chk("rr_done", 32'(done), 32'(1 << (k % 4)));
            chk("rr_eot_fell_first", 32'(saw_low), 32'd1);
        end

        n = 0;
        while (exp_line_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (4 * BIT_CYC) @(negedge clk);
        chk("line_queue_empty", 32'(exp_line_q.size()), 32'd0);
        chk("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_txd transmitter (8N1, start_txd/end_of_txd handshake) among NUM_REQ byte producers with round-robin arbitration.
- Latches the winner's byte and drives start_txd/input_data until the transmitter reports completion.
- Returns a done or err pulse to the owning requester.
- Sits between the system-side byte sources and the UART TX, which must never see data change mid-frame.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 150000, clk cycles allowed from grant to end_of_txd rising edge before abort (> 12 bit periods at 100 MHz / 9600 baud).
- CNT_W, 18, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  asynchronous, active-high reset.
- req  in  NUM_REQ  per-requester transmit request, level.
- req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot, high while requester owns the UART.
- done  out  NUM_REQ  one-cycle pulse to the owner on successful completion.
- err  out  NUM_REQ  one-cycle pulse to the owner on timeout.
- busy  out  1  high whenever state is not ARB.
- start_txd  out  1  to uart_txd start_txd.
- tx_data  out  8  to uart_txd input_data; held stable for the whole ownership.
- end_of_txd  in  1  from uart_txd; goes high at frame end and stays high until the UART's next baud tick.

Behaviour:
- Reset (async, immediate): state=ARB, gnt=0, done=0, err=0, busy=0, start_txd=0, tx_data=0, rr_ptr=0, timeout counter=0, end_of_txd edge register=0.
- All outputs are registered.
- States: ARB, XFER, RELEASE.
- ARB:
  - If any req bit is high, pick the first requester with req high, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - On that edge: gnt[w]=1, tx_data=req_data[w], start_txd=1, counter=0, go to XFER.
  - Grant latency is 1 clk from req sampled high.
  - If no req is high, stay in ARB with all outputs idle.
- XFER:
  - start_txd and tx_data are held; the counter increments every clk.
  - Completion is the rising edge of end_of_txd (registered previous value 0, current value 1).
  - A level that is already high on XFER entry (left over from the previous frame) is not completion.
  - On completion: start_txd=0, done[w]=1, go to RELEASE.
  - start_txd falls thousands of cycles before the UART's next baud tick, so there is no unintended retransmit.
  - If counter == TIMEOUT_CYCLES-1 before completion: start_txd=0, err[w]=1, go to RELEASE.
  - Completion and timeout in the same cycle: completion wins, so done=1 and err=0.
- RELEASE (1 clk):
  - done and err return to 0; gnt=0; rr_ptr=(w+1) mod NUM_REQ; go to ARB.
  - The next grant can therefore come no earlier than 2 clks after the done pulse.
- Requester protocol:
  - Only gnt/done/err change ownership.
  - Dropping req while granted does not abort the frame; done is still pulsed.
  - A requester that keeps req high after done is re-queued behind the others (fairness through rr_ptr).
  - req_data is sampled only at the grant edge.
- Back-to-back: a new start_txd may assert while end_of_txd is still high from the previous frame. The UART then starts on its next baud tick, and completion waits for the next rising edge.
- Reset mid-transfer drops start_txd at once. The UART finishes or resets on its own. Any stale end_of_txd high level is ignored by the edge rule.
- Exactly one bit of gnt|done|err belongs to the owner; no output is ever asserted for a non-owner.

Test Plan:
- Single request: req=0001, req_data[7:0]=0xA5. Required: gnt=0001 and start_txd=1 one clk later with tx_data=0xA5. Line carries 0,1,0,1,0,0,1,0,1 then 1 (LSB first). done[0] pulses once at the end_of_txd rise. busy=0 two clks after done.
- Round-robin: req=1111 held, bytes 0x11/0x22/0x33/0x44. Required grant order 0,1,2,3,0, with UART frames in that same byte order.
- Fairness with a held request: req0 held high, req2 rises during req0's frame. Required: the next grant goes to requester 2 before requester 0 is served again.
- Timeout: UART model never raises end_of_txd, TIMEOUT_CYCLES=1000. Required: err[owner] pulses exactly 1000 clks after the grant, start_txd=0, done stays 0, and the next requester is granted.
- Stale end_of_txd: grant issued while end_of_txd is still high from the previous frame. Required: no done until end_of_txd falls and rises again.
- Async reset mid-XFER: rst pulsed for 3 clks. Required: gnt, start_txd and busy clear immediately with no clk edge. After release, pending req0 is granted first (rr_ptr=0).
